// File: rtl/pc_sequencer.sv
// Next-PC sequencer: picks trap / EX branch / ID jump / pc+4, stalls Pc and flushes the pipeline.
// Optional perf counters are built when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0008
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        id_shouldStall,
  input  logic        id_jump,
  input  logic [31:0] id_jumpTarget,
  input  logic        ex_branchTaken,
  input  logic [31:0] ex_branchTarget,
  input  logic        trap,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] nextPc,
  output logic        pc_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    PEND = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_next;
  logic [1:0]  pend_prio;
  logic [1:0]  pend_prio_next;

  logic        redir;
  logic [1:0]  prio;
  logic [31:0] tgt;
  logic [31:0] seq;
  logic        take_new;
  logic [31:0] pend_eff_pc;
  logic [1:0]  pend_eff_prio;

  // Winning redirect: trap beats EX branch beats ID jump.
  always_comb begin
    prio = 2'd0;
    tgt  = id_jumpTarget;
    if (trap) begin
      prio = 2'd3;
      tgt  = TRAP_VEC;
    end else if (ex_branchTaken) begin
      prio = 2'd2;
      tgt  = ex_branchTarget;
    end else if (id_jump) begin
      prio = 2'd1;
      tgt  = id_jumpTarget;
    end
  end

  assign redir = trap | ex_branchTaken | id_jump;
  assign seq   = pc + 32'd4;

  // Equal priority replaces the held target so the youngest redirect of that class wins.
  assign take_new      = redir && (prio >= pend_prio);
  assign pend_eff_pc   = take_new ? tgt  : pend_pc;
  assign pend_eff_prio = take_new ? prio : pend_prio;

  always_comb begin
    state_next     = state;
    pend_pc_next   = pend_pc;
    pend_prio_next = pend_prio;
    nextPc         = pc;
    pc_stall       = 1'b0;
    imem_req       = 1'b1;
    if_flush       = 1'b0;
    id_flush       = 1'b0;

    if (state != BOOT && redir) begin
      if_flush = 1'b1;
      id_flush = trap | ex_branchTaken;
    end

    case (state)
      BOOT: begin
        nextPc     = RESET_PC;
        imem_req   = 1'b0;
        if_flush   = 1'b1;
        id_flush   = 1'b1;
        state_next = RUN;
      end

      RUN: begin
        if (redir) begin
          if (imem_ready) begin
            nextPc = tgt;
          end else begin
            pend_pc_next   = tgt;
            pend_prio_next = prio;
            pc_stall       = 1'b1;
            state_next     = PEND;
          end
        end else if (id_shouldStall) begin
          pc_stall = 1'b1;
        end else if (!imem_ready) begin
          pc_stall   = 1'b1;
          state_next = WAIT;
        end else begin
          nextPc = seq;
        end
      end

      WAIT: begin
        if (redir) begin
          if (imem_ready) begin
            nextPc     = tgt;
            state_next = RUN;
          end else begin
            pend_pc_next   = tgt;
            pend_prio_next = prio;
            pc_stall       = 1'b1;
            state_next     = PEND;
          end
        end else if (imem_ready) begin
          nextPc     = seq;
          pc_stall   = id_shouldStall;
          state_next = RUN;
        end else begin
          pc_stall = 1'b1;
        end
      end

      PEND: begin
        if (imem_ready) begin
          nextPc         = pend_eff_pc;
          pend_prio_next = 2'd0;
          state_next     = RUN;
        end else begin
          pc_stall       = 1'b1;
          pend_pc_next   = pend_eff_pc;
          pend_prio_next = pend_eff_prio;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      pend_pc   <= RESET_PC;
      pend_prio <= 2'd0;
    end else begin
      state     <= state_next;
      pend_pc   <= pend_pc_next;
      pend_prio <= pend_prio_next;
    end
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;

  // Counters wrap naturally and are cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'h0;
      redir_cnt <= 32'h0;
    end else begin
      if (state != BOOT && pc_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (state != BOOT && redir) begin
        redir_cnt <= redir_cnt + 32'd1;
      end
    end
  end

  assign stall_cycles   = stall_cnt;
  assign redirect_count = redir_cnt;
`else
  assign stall_cycles   = 32'h0;
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; models the external Pc register.
// Perf counter expectations follow PC_SEQ_PERF_CNT_EN.
module tb_pc_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc;
  logic        id_shouldStall;
  logic        id_jump;
  logic [31:0] id_jumpTarget;
  logic        ex_branchTaken;
  logic [31:0] ex_branchTarget;
  logic        trap;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] nextPc;
  logic        pc_stall;
  logic        if_flush;
  logic        id_flush;
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;

  int checkCount;
  int errorCount;

`ifdef PC_SEQ_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd2;
  localparam logic [31:0] EXP_REDIRS = 32'd1;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_REDIRS = 32'd0;
`endif

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0008)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc              (pc),
    .id_shouldStall  (id_shouldStall),
    .id_jump         (id_jump),
    .id_jumpTarget   (id_jumpTarget),
    .ex_branchTaken  (ex_branchTaken),
    .ex_branchTarget (ex_branchTarget),
    .trap            (trap),
    .imem_ready      (imem_ready),
    .imem_req        (imem_req),
    .nextPc          (nextPc),
    .pc_stall        (pc_stall),
    .if_flush        (if_flush),
    .id_flush        (id_flush),
    .stall_cycles    (stall_cycles),
    .redirect_count  (redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pc register: loads nextPc unless stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc <= 32'h0;
    else if (!pc_stall) pc <= nextPc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic stallIn, input logic jumpIn, input logic [31:0] jumpTgt,
                               input logic branchIn, input logic [31:0] branchTgt,
                               input logic trapIn, input logic readyIn);
    @(negedge clock);
    id_shouldStall  = stallIn;
    id_jump         = jumpIn;
    id_jumpTarget   = jumpTgt;
    ex_branchTaken  = branchIn;
    ex_branchTarget = branchTgt;
    trap            = trapIn;
    imem_ready      = readyIn;
    #1;
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    reset_n         = 1'b0;
    id_shouldStall  = 1'b0;
    id_jump         = 1'b0;
    id_jumpTarget   = 32'h0;
    ex_branchTaken  = 1'b0;
    ex_branchTarget = 32'h0;
    trap            = 1'b0;
    imem_ready      = 1'b1;
    $display("[TB] start");

    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_nextPc", nextPc, 32'h0);
    checkOutput("rst_stall", {31'h0, pc_stall}, 32'h0);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_if_flush", {31'h0, if_flush}, 32'h1);
    checkOutput("rst_id_flush", {31'h0, id_flush}, 32'h1);
    checkOutput("rst_stall_cnt", stall_cycles, 32'h0);
    checkOutput("rst_redir_cnt", redirect_count, 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("boot_nextPc", nextPc, 32'h0);
    checkOutput("boot_req", {31'h0, imem_req}, 32'h0);
    checkOutput("boot_if_flush", {31'h0, if_flush}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("seq_pc", pc, 32'(i * 4));
      checkOutput("seq_nextPc", nextPc, 32'(i * 4 + 4));
      checkOutput("seq_if_flush", {31'h0, if_flush}, 32'h0);
      checkOutput("seq_id_flush", {31'h0, id_flush}, 32'h0);
      checkOutput("seq_req", {31'h0, imem_req}, 32'h1);
    end

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      checkOutput("lu_pc", pc, 32'h10);
      checkOutput("lu_stall", {31'h0, pc_stall}, 32'h1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("lu_release_nextPc", nextPc, 32'h14);

    applyStimulus(0, 1, 32'h80, 1, 32'h40, 1, 1);
    checkOutput("trap_pc", pc, 32'h14);
    checkOutput("trap_nextPc", nextPc, 32'h8);
    checkOutput("trap_if_flush", {31'h0, if_flush}, 32'h1);
    checkOutput("trap_id_flush", {31'h0, id_flush}, 32'h1);

    applyStimulus(0, 1, 32'h80, 0, 0, 0, 1);
    checkOutput("jump_pc", pc, 32'h8);
    checkOutput("jump_nextPc", nextPc, 32'h80);
    checkOutput("jump_if_flush", {31'h0, if_flush}, 32'h1);
    checkOutput("jump_id_flush", {31'h0, id_flush}, 32'h0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wait_stall", {31'h0, pc_stall}, 32'h1);
    checkOutput("wait_nextPc", nextPc, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("wait_exit_nextPc", nextPc, 32'h84);
    checkOutput("wait_exit_stall", {31'h0, pc_stall}, 32'h0);

    // Branch then lower-priority jump while I-mem is busy: branch target must survive.
    applyStimulus(0, 0, 0, 1, 32'h100, 0, 0);
    checkOutput("pend_br_stall", {31'h0, pc_stall}, 32'h1);
    checkOutput("pend_br_nextPc", nextPc, 32'h84);
    checkOutput("pend_br_id_flush", {31'h0, id_flush}, 32'h1);
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 0);
    checkOutput("pend_jmp_stall", {31'h0, pc_stall}, 32'h1);
    checkOutput("pend_jmp_id_flush", {31'h0, id_flush}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_idle_stall", {31'h0, pc_stall}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("pend_done_nextPc", nextPc, 32'h100);
    checkOutput("pend_done_stall", {31'h0, pc_stall}, 32'h0);

    applyStimulus(0, 1, 32'h300, 0, 0, 0, 0);
    checkOutput("ovr_jmp_stall", {31'h0, pc_stall}, 32'h1);
    applyStimulus(0, 0, 0, 1, 32'h400, 0, 0);
    checkOutput("ovr_br_nextPc", nextPc, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("ovr_done_nextPc", nextPc, 32'h400);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h500, 0, 0);
    checkOutput("wp_stall", {31'h0, pc_stall}, 32'h1);
    checkOutput("wp_if_flush", {31'h0, if_flush}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("wp_done_nextPc", nextPc, 32'h500);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h600, 0, 0, 0, 1);
    checkOutput("wr_nextPc", nextPc, 32'h600);
    checkOutput("wr_stall", {31'h0, pc_stall}, 32'h0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("ws_stall", {31'h0, pc_stall}, 32'h1);
    checkOutput("ws_nextPc", nextPc, 32'h604);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("ws_pc", pc, 32'h600);
    checkOutput("ws_run_nextPc", nextPc, 32'h604);

    // Reset while a branch target is pending: it must be discarded.
    applyStimulus(0, 0, 0, 1, 32'h100, 0, 0);
    checkOutput("pr_stall", {31'h0, pc_stall}, 32'h1);
    @(negedge clock);
    reset_n         = 1'b0;
    ex_branchTaken  = 1'b0;
    imem_ready      = 1'b1;
    #1;
    checkOutput("pr_rst_nextPc", nextPc, 32'h0);
    checkOutput("pr_rst_pc", pc, 32'h0);
    checkOutput("pr_rst_stall_cnt", stall_cycles, 32'h0);
    checkOutput("pr_rst_redir_cnt", redirect_count, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("pr_boot_nextPc", nextPc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("pr_run_pc", pc, 32'h0);
    checkOutput("pr_run_nextPc", nextPc, 32'h4);

    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
    checkOutput("perf_br_nextPc", nextPc, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("perf_pc", pc, 32'h40);
    checkOutput("perf_stall_cnt", stall_cycles, EXP_STALLS);
    checkOutput("perf_redir_cnt", redirect_count, EXP_REDIRS);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
